piso_shift_register: RTL and testbench



---
 rtl/piso_pkg.sv | 21 ++
 rtl/piso_bit_counter.sv | 37 +++
 rtl/piso_shift_register.sv | 99 +++++++++
 tb/tb_piso_shift_register.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the PISO shift register: state encoding and sizing helpers.
// PISO_PARITY_EN adds one trailing even-parity bit to every word.
package piso_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    // Bits sent per word: the data bits, plus the parity bit when it is compiled in.
    function automatic int piso_nbits(input int width);
`ifdef PISO_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

    function automatic int piso_cnt_w(input int nbits);
        return (nbits <= 2) ? 1 : $clog2(nbits);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for the PISO shifter: synchronous clear, enable, terminal count.
// Its sizing follows piso_pkg, which depends on PISO_PARITY_EN.
module piso_bit_counter #(
    parameter int NBITS = 4,
    parameter int CW    = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // NOTE: state updates use <= so every flop samples pre-edge values; combinational logic uses =.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == CW'(NBITS - 1));

endmodule

// File: rtl/piso_shift_register.sv
// Parallel-in, serial-out shifter, LSB first, with a load/ready handshake and valid/ready output.
// Defining PISO_PARITY_EN appends the even parity of the loaded word as a final bit.
module piso_shift_register
    import piso_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [WIDTH-1:0] I,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sready,
    output logic             done
);

    localparam int NBITS = piso_nbits(WIDTH);
    localparam int CW    = piso_cnt_w(NBITS);

    logic             state_q, state_d;
    logic [NBITS-1:0] shreg_q, shreg_d;
    logic             sout_valid_q, sout_valid_d;
    logic             done_q, done_d;

    logic             tc;
    logic             accept;
    logic             transfer;
    logic             last;
    logic [NBITS-1:0] word;

`ifdef PISO_PARITY_EN
    assign word = {^I, I};
`else
    assign word = I;
`endif

    // The last-bit cycle can hand over directly to the next word, so ready opens there too.
    assign ready    = (state_q == ST_IDLE) | (sout_valid_q & sready & tc);
    assign accept   = load & ready;
    assign transfer = sout_valid_q & sready;
    assign last     = transfer & tc;

    piso_bit_counter #(
        .NBITS(NBITS),
        .CW   (CW)
    ) u_cnt (
        .clk (clk),
        .rstn(rstn),
        .clr (accept | last),
        .en  (transfer & ~tc),
        .tc  (tc)
    );

    // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        sout_valid_d = sout_valid_q;
        done_d       = last;

        if (transfer) begin
            if (tc) begin
                state_d      = ST_IDLE;
                sout_valid_d = 1'b0;
                shreg_d      = '0;
            end else begin
                shreg_d = shreg_q >> 1;
            end
        end

        if (accept) begin
            state_d      = ST_SHIFT;
            sout_valid_d = 1'b1;
            shreg_d      = word;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            sout_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            sout_valid_q <= sout_valid_d;
            done_q       <= done_d;
        end
    end

    // The serial bit is the register LSB, so it is registered and stable during a stall.
    assign sout       = shreg_q[0];
    assign sout_valid = sout_valid_q;
    assign done       = done_q;

endmodule

// File: tb/tb_piso_shift_register.sv
// Directed self-checking bench for piso_shift_register (WIDTH=4).
// The parity scenario runs only when PISO_PARITY_EN is defined.
module tb_piso_shift_register;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic             load;
    logic [WIDTH-1:0] I;
    logic             ready;
    logic             sout;
    logic             sout_valid;
    logic             sready;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;

    piso_shift_register #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .load      (load),
        .I         (I),
        .ready     (ready),
        .sout      (sout),
        .sout_valid(sout_valid),
        .sready    (sready),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle 1 time unit past the edge before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic s, input logic r, input logic d);
        check({tag, ".valid"}, 32'(sout_valid), 32'(v));
        check({tag, ".sout"},  32'(sout),       32'(s));
        check({tag, ".ready"}, 32'(ready),      32'(r));
        check({tag, ".done"},  32'(done),       32'(d));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn   = 1'b0;
        load   = 1'b0;
        I      = '0;
        sready = 1'b0;
        #2;
        expect_out("reset", 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        rstn = 1'b1;
        tick();
        expect_out("idle", 1'b0, 1'b0, 1'b1, 1'b0);

        // Basic drain of 1011: bits 1,1,0,1 then a done pulse.
        sready = 1'b1;
        I      = 4'b1011;
        load   = 1'b1;
        tick();
        load = 1'b0;
        I    = 4'b0000;
        expect_out("drain.b0", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("drain.b1", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("drain.b2", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("drain.b3", 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        expect_out("drain.done", 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        expect_out("drain.after", 1'b0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a word.
        I    = 4'b1011;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        expect_out("midrst.b1", 1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        expect_out("midrst.async", 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("midrst.held", 1'b0, 1'b0, 1'b1, 1'b0);
        rstn = 1'b1;
        tick();
        expect_out("midrst.nodone", 1'b0, 1'b0, 1'b1, 1'b0);

        // Backpressure on bit 1 of 0110.
        I    = 4'b0110;
        load = 1'b1;
        tick();
        load = 1'b0;
        expect_out("stall.b0", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("stall.b1", 1'b1, 1'b1, 1'b0, 1'b0);
        check("stall.cnt_start", 32'(dut.u_cnt.cnt_q), 32'd1);
        sready = 1'b0;
        tick();
        expect_out("stall.hold1", 1'b1, 1'b1, 1'b0, 1'b0);
        check("stall.cnt1", 32'(dut.u_cnt.cnt_q), 32'd1);
        tick();
        expect_out("stall.hold2", 1'b1, 1'b1, 1'b0, 1'b0);
        check("stall.cnt2", 32'(dut.u_cnt.cnt_q), 32'd1);
        tick();
        expect_out("stall.hold3", 1'b1, 1'b1, 1'b0, 1'b0);
        check("stall.cnt3", 32'(dut.u_cnt.cnt_q), 32'd1);
        sready = 1'b1;
        tick();
        expect_out("stall.b2", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("stall.b3", 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("stall.done", 1'b0, 1'b0, 1'b1, 1'b1);

        // Back-to-back: 0011 then 1100 loaded in the last-bit cycle.
        I    = 4'b0011;
        load = 1'b1;
        tick();
        load = 1'b0;
        expect_out("b2b.a0", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("b2b.a1", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("b2b.a2", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("b2b.a3", 1'b1, 1'b0, 1'b1, 1'b0);
        I    = 4'b1100;
        load = 1'b1;
        tick();
        load = 1'b0;
        I    = 4'b1111;
        expect_out("b2b.b0", 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        expect_out("b2b.b1", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("b2b.b2", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("b2b.b3", 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        expect_out("b2b.done", 1'b0, 1'b0, 1'b1, 1'b1);

        // Load while busy is ignored.
        I    = 4'b0001;
        load = 1'b1;
        tick();
        I = 4'b1111;
        expect_out("ign.b0", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        load = 1'b0;
        expect_out("ign.b1", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("ign.b2", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("ign.b3", 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("ign.done", 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        expect_out("ign.idle", 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef PISO_PARITY_EN
        // 0111: data 1,1,1,0 then parity 1.
        I    = 4'b0111;
        load = 1'b1;
        tick();
        load = 1'b0;
        expect_out("par1.b0", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("par1.b1", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("par1.b2", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("par1.b3", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("par1.p", 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        expect_out("par1.done", 1'b0, 1'b0, 1'b1, 1'b1);

        // 0011: data 1,1,0,0 then parity 0.
        I    = 4'b0011;
        load = 1'b1;
        tick();
        load = 1'b0;
        expect_out("par2.b0", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("par2.b1", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("par2.b2", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("par2.b3", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("par2.p", 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("par2.done", 1'b0, 1'b0, 1'b1, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
